// File: rtl/lbist_pkg.sv
// Shared types for the logic-BIST sequencer: FSM states, the registered
// control-output bundle and its per-state decode.
package lbist_pkg;

    localparam int LBIST_CNT_W  = 16;
    localparam int LBIST_SE_GAP = 2;

    typedef enum logic [2:0] {
        IDLE,
        SEED,
        SHIFT,
        GAP_PRE,
        CAPTURE,
        GAP_POST,
        UNLOAD,
        DONE
    } lbist_state_e;

    typedef struct packed {
        logic scan_en;
        logic scan_shift;
        logic scan_capture;
        logic prpg_load;
        logic prpg_en;
        logic misr_clr;
        logic misr_en;
        logic busy;
        logic done;
    } lbist_ctl_t;

    // misr_ok is low only while the very first pattern is being shifted in,
    // so the MISR never compacts the uninitialised chain contents.
    function automatic lbist_ctl_t lbist_decode(input lbist_state_e st, input logic misr_ok);
        lbist_ctl_t c;
        c = '0;
        case (st)
            SEED: begin
                c.prpg_load = 1'b1;
                c.misr_clr  = 1'b1;
                c.busy      = 1'b1;
            end
            SHIFT: begin
                c.scan_en    = 1'b1;
                c.scan_shift = 1'b1;
                c.prpg_en    = 1'b1;
                c.misr_en    = misr_ok;
                c.busy       = 1'b1;
            end
            GAP_PRE: begin
                c.scan_en = 1'b1;
                c.busy    = 1'b1;
            end
            CAPTURE: begin
                c.scan_capture = 1'b1;
                c.busy         = 1'b1;
            end
            GAP_POST: begin
                c.busy = 1'b1;
            end
            UNLOAD: begin
                c.scan_en    = 1'b1;
                c.scan_shift = 1'b1;
                c.misr_en    = 1'b1;
                c.busy       = 1'b1;
            end
            DONE: begin
                c.done = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/lbist_shift_cnt.sv
// Loadable down-counter with a zero flag; times the SHIFT/UNLOAD phases and
// the optional scan-enable settling gaps.
module lbist_shift_cnt
    import lbist_pkg::*;
#(
    parameter int CNT_W = LBIST_CNT_W
) (
    input  logic             mclk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    // Holds at zero once exhausted so an idle counter never wraps.
    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/lbist_ctrl.sv
// Logic-BIST sequencer: SEED, then shift/capture per pattern, a final unload
// and a sticky done. Define LBIST_SE_GAP_EN to add scan-enable settling gaps.
module lbist_ctrl
    import lbist_pkg::*;
#(
    parameter int CNT_W  = LBIST_CNT_W,
    parameter int SE_GAP = LBIST_SE_GAP
) (
    input  logic             mclk,
    input  logic             reset_n,
    input  logic             cfg_lbist_rst,
    input  logic             cfg_lbist_start,
    input  logic [CNT_W-1:0] cfg_lbist_pat,
    input  logic [CNT_W-1:0] cfg_chain_depth,
    output logic             lbist_done,
    output logic             lbist_busy,
    output logic             scan_en,
    output logic             scan_shift,
    output logic             scan_capture,
    output logic             prpg_load,
    output logic             prpg_en,
    output logic             misr_clr,
    output logic             misr_en,
    output logic [CNT_W-1:0] pat_cnt
);

`ifdef LBIST_SE_GAP_EN
    localparam bit GAP_ON = 1'b1;
`else
    localparam bit GAP_ON = 1'b0;
`endif
    localparam int               GAP_LEN = (SE_GAP < 1) ? 1 : SE_GAP;
    localparam logic [CNT_W-1:0] GAP_M1  = CNT_W'(GAP_LEN - 1);

    lbist_state_e     state;
    lbist_state_e     state_nxt;
    lbist_ctl_t       ctl_q;
    logic             start_q;
    logic             start_evt;
    logic [CNT_W-1:0] pat_l;
    logic [CNT_W-1:0] dep_l;
    logic [CNT_W-1:0] dep_m1;
    logic [CNT_W-1:0] pat_inc;
    logic [CNT_W-1:0] pat_cnt_nxt;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_val;
    logic             cnt_zero;

    assign start_evt = cfg_lbist_start & ~start_q & ((state == IDLE) | (state == DONE));
    assign dep_m1    = dep_l - 1'b1;
    assign pat_inc   = (pat_cnt == '1) ? pat_cnt : pat_cnt + 1'b1;

    lbist_shift_cnt #(
        .CNT_W(CNT_W)
    ) u_shift_cnt (
        .mclk    (mclk),
        .reset_n (reset_n),
        .clr     (cfg_lbist_rst),
        .load    (cnt_load),
        .load_val(cnt_load_val),
        .zero    (cnt_zero)
    );

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            start_q <= 1'b0;
            pat_l   <= '0;
            dep_l   <= CNT_W'(1);
        end else if (cfg_lbist_rst) begin
            start_q <= 1'b0;
            pat_l   <= '0;
            dep_l   <= CNT_W'(1);
        end else begin
            start_q <= cfg_lbist_start;
            if (start_evt) begin
                pat_l <= cfg_lbist_pat;
                dep_l <= (cfg_chain_depth == '0) ? CNT_W'(1) : cfg_chain_depth;
            end
        end
    end

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            pat_cnt <= '0;
            ctl_q   <= '0;
        end else begin
            state   <= state_nxt;
            pat_cnt <= pat_cnt_nxt;
            ctl_q   <= lbist_decode(state_nxt, pat_cnt_nxt != '0);
        end
    end

    // The counter is reloaded on every entry to a timed state; software reset
    // overrides whatever the state decode chose.
    always_comb begin
        state_nxt    = state;
        pat_cnt_nxt  = pat_cnt;
        cnt_load     = 1'b0;
        cnt_load_val = dep_m1;
        case (state)
            IDLE, DONE: begin
                if (start_evt) begin
                    state_nxt   = SEED;
                    pat_cnt_nxt = '0;
                end
            end
            SEED: begin
                if (pat_l == '0) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = SHIFT;
                    cnt_load  = 1'b1;
                end
            end
            SHIFT: begin
                if (cnt_zero) begin
                    if (GAP_ON) begin
                        state_nxt    = GAP_PRE;
                        cnt_load     = 1'b1;
                        cnt_load_val = GAP_M1;
                    end else begin
                        state_nxt = CAPTURE;
                    end
                end
            end
            GAP_PRE: begin
                if (cnt_zero) begin
                    state_nxt = CAPTURE;
                end
            end
            CAPTURE: begin
                pat_cnt_nxt = pat_inc;
                cnt_load    = 1'b1;
                if (GAP_ON) begin
                    state_nxt    = GAP_POST;
                    cnt_load_val = GAP_M1;
                end else begin
                    state_nxt = (pat_inc == pat_l) ? UNLOAD : SHIFT;
                end
            end
            GAP_POST: begin
                if (cnt_zero) begin
                    state_nxt = (pat_cnt == pat_l) ? UNLOAD : SHIFT;
                    cnt_load  = 1'b1;
                end
            end
            UNLOAD: begin
                if (cnt_zero) begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (cfg_lbist_rst) begin
            state_nxt   = IDLE;
            pat_cnt_nxt = '0;
            cnt_load    = 1'b0;
        end
    end

    assign lbist_done   = ctl_q.done;
    assign lbist_busy   = ctl_q.busy;
    assign scan_en      = ctl_q.scan_en;
    assign scan_shift   = ctl_q.scan_shift;
    assign scan_capture = ctl_q.scan_capture;
    assign prpg_load    = ctl_q.prpg_load;
    assign prpg_en      = ctl_q.prpg_en;
    assign misr_clr     = ctl_q.misr_clr;
    assign misr_en      = ctl_q.misr_en;

endmodule

// File: tb/tb_lbist_ctrl.sv
// Randomised bench for lbist_ctrl: a per-run expected output trace built from
// the phase rules, plus run-level busy/capture totals from the cycle formula.
module tb_lbist_ctrl;

    localparam int CNT_W  = 16;
    localparam int SE_GAP = 2;
    localparam int OUT_W  = 9 + CNT_W;

    logic             mclk = 1'b0;
    logic             reset_n;
    logic             cfg_lbist_rst;
    logic             cfg_lbist_start;
    logic [CNT_W-1:0] cfg_lbist_pat;
    logic [CNT_W-1:0] cfg_chain_depth;
    logic             lbist_done;
    logic             lbist_busy;
    logic             scan_en;
    logic             scan_shift;
    logic             scan_capture;
    logic             prpg_load;
    logic             prpg_en;
    logic             misr_clr;
    logic             misr_en;
    logic [CNT_W-1:0] pat_cnt;

    int               n_checks = 0;
    int               n_fail   = 0;
    logic [OUT_W-1:0] exp_q[$];
    logic [OUT_W-1:0] hold_vec;
    int               busy_seen;
    int               cap_seen;
    bit               start_hold;

    always #5 mclk = ~mclk;

    lbist_ctrl dut (
        .mclk           (mclk),
        .reset_n        (reset_n),
        .cfg_lbist_rst  (cfg_lbist_rst),
        .cfg_lbist_start(cfg_lbist_start),
        .cfg_lbist_pat  (cfg_lbist_pat),
        .cfg_chain_depth(cfg_chain_depth),
        .lbist_done     (lbist_done),
        .lbist_busy     (lbist_busy),
        .scan_en        (scan_en),
        .scan_shift     (scan_shift),
        .scan_capture   (scan_capture),
        .prpg_load      (prpg_load),
        .prpg_en        (prpg_en),
        .misr_clr       (misr_clr),
        .misr_en        (misr_en),
        .pat_cnt        (pat_cnt)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int gap_len();
`ifdef LBIST_SE_GAP_EN
        return SE_GAP;
`else
        return 0;
`endif
    endfunction

    function automatic logic [OUT_W-1:0] mk(input bit done, busy, se, sh, cap, pl, pe, mc, me,
                                            input int pc);
        return {done, busy, se, sh, cap, pl, pe, mc, me, CNT_W'(pc)};
    endfunction

    function automatic logic [OUT_W-1:0] observed();
        return {lbist_done, lbist_busy, scan_en, scan_shift, scan_capture,
                prpg_load, prpg_en, misr_clr, misr_en, pat_cnt};
    endfunction

    // Expected trace, one vector per cycle from SEED through the first DONE cycle.
    task automatic push_run(input int pat, input int dep);
        int d;
        d = (dep == 0) ? 1 : dep;
        exp_q.push_back(mk(0, 1, 0, 0, 0, 1, 0, 1, 0, 0));
        if (pat > 0) begin
            for (int p = 0; p < pat; p++) begin
                for (int i = 0; i < d; i++) exp_q.push_back(mk(0, 1, 1, 1, 0, 0, 1, 0, (p != 0), p));
                for (int i = 0; i < gap_len(); i++) exp_q.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, p));
                exp_q.push_back(mk(0, 1, 0, 0, 1, 0, 0, 0, 0, p));
                for (int i = 0; i < gap_len(); i++) exp_q.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, p + 1));
            end
            for (int i = 0; i < d; i++) exp_q.push_back(mk(0, 1, 1, 1, 0, 0, 0, 0, 1, pat));
        end
        hold_vec = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, pat);
        exp_q.push_back(hold_vec);
    endtask

    task automatic step();
        logic [OUT_W-1:0] exp;
        @(negedge mclk);
        if (exp_q.size() > 0) exp = exp_q.pop_front();
        else exp = hold_vec;
        check_val("trace", observed(), exp);
        if (lbist_busy) busy_seen++;
        if (scan_capture) cap_seen++;
    endtask

    task automatic start_run(input int pat, input int dep, input bit hold);
        if (cfg_lbist_start) begin
            cfg_lbist_start = 1'b0;
            step();
        end
        cfg_lbist_pat   = CNT_W'(pat);
        cfg_chain_depth = CNT_W'(dep);
        cfg_lbist_start = 1'b1;
        start_hold      = hold;
        push_run(pat, dep);
    endtask

    task automatic wait_done(input int pat, input int dep, input bit disturb);
        int d;
        int exp_busy;
        int n;
        d        = (dep == 0) ? 1 : dep;
        exp_busy = (pat == 0) ? 1 : 1 + pat * (d + 1 + 2 * gap_len()) + d;
        n        = 0;
        busy_seen = 0;
        cap_seen  = 0;
        while (exp_q.size() > 0 && n < exp_busy + 8) begin
            step();
            n++;
            if (n == 1 && !start_hold) cfg_lbist_start = 1'b0;
            if (disturb && exp_q.size() > 0) begin
                case ($urandom_range(0, 3))
                    0: cfg_lbist_pat = CNT_W'($urandom);
                    1: cfg_chain_depth = CNT_W'($urandom);
                    2: cfg_lbist_start = ~cfg_lbist_start;
                    default: ;
                endcase
            end
        end
        check_val("run_timeout", exp_q.size(), 0);
        check_val("busy_cycles", busy_seen, exp_busy);
        check_val("captures", cap_seen, pat);
        check_val("pat_cnt_done", pat_cnt, pat);
        check_val("done_flag", lbist_done, 1);
    endtask

    task automatic sw_reset(input int after);
        for (int i = 0; i < after; i++) begin
            step();
            if (i == 0) cfg_lbist_start = 1'b0;
        end
        cfg_lbist_rst = 1'b1;
        exp_q.delete();
        hold_vec = '0;
        step();
        check_val("rst_done_clr", lbist_done, 0);
        check_val("rst_outputs", observed(), 0);
        cfg_lbist_rst = 1'b0;
        step();
    endtask

    initial begin
        int pat;
        int dep;
        reset_n         = 1'b0;
        cfg_lbist_rst   = 1'b0;
        cfg_lbist_start = 1'b0;
        cfg_lbist_pat   = '0;
        cfg_chain_depth = '0;
        hold_vec        = '0;
        start_hold      = 1'b0;
        step();
        step();
        check_val("reset_outputs", observed(), 0);
        reset_n = 1'b1;
        repeat (3) step();

        start_run(2, 4, 0);
        wait_done(2, 4, 0);
        repeat (2) step();

        start_run(0, 8, 0);
        wait_done(0, 8, 0);

        start_run(1, 0, 0);
        wait_done(1, 0, 0);

        start_run(3, 4, 0);
        sw_reset(6);
        start_run(3, 4, 0);
        wait_done(3, 4, 0);

        start_run(2, 3, 1);
        wait_done(2, 3, 0);
        start_run(3, 2, 0);
        wait_done(3, 2, 1);

        start_run(1, 2, 0);
        wait_done(1, 2, 0);

        for (int r = 0; r < 30; r++) begin
            pat = $urandom_range(0, 5);
            dep = $urandom_range(0, 7);
            start_run(pat, dep, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 5) == 0) sw_reset($urandom_range(1, 10));
            else wait_done(pat, dep, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
